// File: rtl/demo_audio.sv
// demo_audio: 16-step tone + noise-hat sequencer, per-frame envelopes,
// first-order sigma-delta to a 1-bit audio stream.
// Ports: clk, reset (async, active-low), new_frame, frame_counter,
//        sample_out (7b mixed sample), audio_out (1b bitstream).
module demo_audio #(
  parameter int FRAME_COUNTER_BITS   = 11,
  parameter int SAMPLE_DIV           = 100,
  parameter int PHASE_BITS           = 14,
  parameter int FRAMES_PER_STEP_LOG2 = 3,
  parameter int TONE_DECAY           = 4,
  parameter int NOISE_DECAY          = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          new_frame,
  input  logic [FRAME_COUNTER_BITS-1:0] frame_counter,
  output logic [6:0]                    sample_out,
  output logic                          audio_out
);

  localparam int DIV_W =
    (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST =
    DIV_W'(SAMPLE_DIV - 1);
  localparam logic [5:0] TDEC = 6'(TONE_DECAY);
  localparam logic [4:0] NDEC = 5'(NOISE_DECAY);

  logic [DIV_W-1:0]      div_cnt;
  logic                  tick;
  logic [PHASE_BITS-1:0] phase;
  logic [5:0]            tone_env;
  logic [4:0]            noise_env;
  logic [3:0]            cur_step;
  logic [3:0]            step;
  logic                  step_valid;
  logic [15:0]           lfsr;
  logic                  fb;
  logic [6:0]            acc;
  logic [7:0]            sd_sum;
  logic [7:0]            cur_inc;
  logic [7:0]            new_inc;
  logic                  retrig;
  logic [5:0]            tone_s;
  logic [4:0]            noise_s;
  logic [5:0]            tone_dec;
  logic [4:0]            noise_dec;
  logic                  unused_fc;

  function automatic logic [7:0] note_inc(
    input logic [3:0] s
  );
    case (s)
      4'd0:    note_inc = 8'd32;
      4'd2:    note_inc = 8'd40;
      4'd4:    note_inc = 8'd48;
      4'd6:    note_inc = 8'd40;
      4'd7:    note_inc = 8'd32;
      4'd8:    note_inc = 8'd36;
      4'd10:   note_inc = 8'd48;
      4'd12:   note_inc = 8'd54;
      4'd13:   note_inc = 8'd48;
      4'd14:   note_inc = 8'd40;
      default: note_inc = 8'd0;
    endcase
  endfunction

  assign step =
    frame_counter[FRAMES_PER_STEP_LOG2+3 -: 4];
  assign unused_fc = ^frame_counter;

  assign tick    = (div_cnt == DIV_LAST);
  assign cur_inc = note_inc(cur_step);
  assign new_inc = note_inc(step);

  // First frame after reset always retriggers.
  assign retrig = new_frame &&
    (!step_valid || (step != cur_step));

  assign tone_dec  = (tone_env > TDEC) ?
    tone_env - TDEC : 6'd0;
  assign noise_dec = (noise_env > NDEC) ?
    noise_env - NDEC : 5'd0;

  assign fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  assign tone_s  = phase[PHASE_BITS-1] ?
    tone_env : 6'd0;
  assign noise_s = lfsr[0] ? noise_env : 5'd0;

  assign sd_sum = {1'b0, acc} + {1'b0, sample_out};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Phase reset on retrigger is written last so it
  // overrides a coincident tick advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase      <= '0;
      tone_env   <= '0;
      noise_env  <= '0;
      cur_step   <= '0;
      step_valid <= 1'b0;
    end else begin
      if (tick) begin
        phase <= phase + PHASE_BITS'(cur_inc);
      end
      if (retrig) begin
        cur_step   <= step;
        step_valid <= 1'b1;
        if (new_inc != 8'd0) begin
          phase    <= '0;
          tone_env <= 6'd63;
        end else begin
          tone_env <= 6'd0;
        end
        if (step[1:0] == 2'b10) begin
          noise_env <= 5'd31;
        end
      end else if (new_frame) begin
        tone_env  <= tone_dec;
        noise_env <= noise_dec;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr <= 16'h0001;
    end else if (tick) begin
      lfsr <= {fb, lfsr[15:1]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_out <= '0;
      acc        <= '0;
      audio_out  <= 1'b0;
    end else begin
      sample_out <= {1'b0, tone_s} + {2'b0, noise_s};
      acc        <= sd_sum[6:0];
      audio_out  <= sd_sum[7];
    end
  end

endmodule

// File: tb/tb_demo_audio.sv
// tb_demo_audio: table vectors, hand sequences and random frames
// checked against an arithmetic reference model of demo_audio.
module tb_demo_audio;

  localparam int SAMPLE_DIV = 100;
  localparam int FPS_LOG2   = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        new_frame = 1'b0;
  logic [10:0] frame_counter = '0;
  logic [6:0]  sample_out;
  logic        audio_out;

  demo_audio dut (
    .clk           (clk),
    .reset         (reset),
    .new_frame     (new_frame),
    .frame_counter (frame_counter),
    .sample_out    (sample_out),
    .audio_out     (audio_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name,
                       input int act,
                       input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  // Reference model: integer arithmetic from the rules.
  int inc_tab[16] = '{32, 0, 40, 0, 48, 0, 40, 32,
                      36, 0, 48, 0, 54, 48, 40, 0};
  int m_div = 0, m_phase = 0, m_tone = 0, m_noise = 0;
  int m_step = 0, m_valid = 0, m_lfsr = 1, m_acc = 0;
  int m_samp = 0, m_audio = 0;
  int t, sum, s, fb;
  int n_phase, n_lfsr, n_tone, n_noise, n_step, n_valid;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_div = 0; m_phase = 0; m_tone = 0; m_noise = 0;
      m_step = 0; m_valid = 0; m_lfsr = 1; m_acc = 0;
      m_samp = 0; m_audio = 0;
    end else begin
      t = (m_div == SAMPLE_DIV - 1);
      sum = m_acc + m_samp;
      n_phase = t ? (m_phase + inc_tab[m_step]) % 16384
                  : m_phase;
      n_lfsr = m_lfsr;
      if (t) begin
        fb = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3)
              ^ (m_lfsr >> 5)) & 1;
        n_lfsr = (m_lfsr >> 1) + fb * 32768;
      end
      n_tone = m_tone; n_noise = m_noise;
      n_step = m_step; n_valid = m_valid;
      if (new_frame) begin
        s = (int'(frame_counter) >> FPS_LOG2) % 16;
        if (!m_valid || s != m_step) begin
          n_step = s; n_valid = 1;
          if (inc_tab[s] != 0) begin
            n_phase = 0; n_tone = 63;
          end else n_tone = 0;
          if (s % 4 == 2) n_noise = 31;
        end else begin
          n_tone  = (m_tone > 4) ? m_tone - 4 : 0;
          n_noise = (m_noise > 8) ? m_noise - 8 : 0;
        end
      end
      m_samp = ((m_phase >= 8192) ? m_tone : 0)
             + ((m_lfsr % 2 == 1) ? m_noise : 0);
      m_acc = sum % 128;
      m_audio = sum / 128;
      m_div = (m_div + 1) % SAMPLE_DIV;
      m_phase = n_phase; m_lfsr = n_lfsr;
      m_tone = n_tone; m_noise = n_noise;
      m_step = n_step; m_valid = n_valid;
    end
  end

  always @(negedge clk) begin
    check("sample_out", int'(sample_out), m_samp);
    check("audio_out", int'(audio_out), m_audio);
  end

  typedef struct {
    int fc;
    int tone;
    int noise;
  } vec_t;

  vec_t vec[25];

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int fc);
    frame_counter = 11'(fc);
    new_frame = 1'b1;
    @(negedge clk);
    new_frame = 1'b0;
  endtask

  initial begin
    int n, nz, ones, fc, prev;
    vec = '{
      '{1, 59, 0},  '{2, 55, 0},  '{3, 51, 0},
      '{4, 47, 0},  '{5, 43, 0},  '{6, 39, 0},
      '{7, 35, 0},  '{7, 31, 0},  '{7, 27, 0},
      '{7, 23, 0},  '{7, 19, 0},  '{7, 15, 0},
      '{7, 11, 0},  '{7, 7, 0},   '{7, 3, 0},
      '{7, 0, 0},   '{7, 0, 0},   '{8, 0, 0},
      '{16, 63, 31}, '{17, 59, 23}, '{18, 55, 15},
      '{19, 51, 7},  '{20, 47, 0},  '{21, 43, 0},
      '{127, 0, 0}
    };

    repeat (3) @(negedge clk);
    check("rst_lfsr", int'(dut.lfsr), 1);
    check("rst_tone", int'(dut.tone_env), 0);
    reset = 1'b1;

    nz = 0;
    repeat (1000) begin
      @(negedge clk);
      if (sample_out != 0 || audio_out != 0) nz++;
    end
    check("quiet_nonzero_cycles", nz, 0);

    pulse(0);
    check("first_tone", int'(dut.tone_env), 63);
    check("first_phase", int'(dut.phase), 0);
    n = 0;
    while (sample_out == 0 && n < 30000) begin
      @(negedge clk);
      n++;
    end
    check("tone_onset_in_window",
          int'(n >= 25400 && n <= 25700), 1);
    check("tone_level", int'(sample_out), 63);
    idle(10);
    ones = 0;
    repeat (128) begin
      @(negedge clk);
      ones += int'(audio_out);
    end
    check("ones_per_128", ones, 63);

    foreach (vec[i]) begin
      idle(int'($urandom_range(20, 200)));
      pulse(vec[i].fc);
      check($sformatf("tone_env_v%0d", i),
            int'(dut.tone_env), vec[i].tone);
      check($sformatf("noise_env_v%0d", i),
            int'(dut.noise_env), vec[i].noise);
      check($sformatf("phase_v%0d", i),
            int'(dut.phase), m_phase);
    end

    n = 0;
    @(negedge clk);
    while (!dut.tick && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("tick_align", int'(dut.tick), 1);
    pulse(128);
    check("coinc_phase", int'(dut.phase), 0);
    check("coinc_tone", int'(dut.tone_env), 63);
    check("coinc_step", int'(dut.cur_step), 0);
    check("coinc_lfsr", int'(dut.lfsr), m_lfsr);

    idle(50);
    pulse(16);
    idle(50);
    pulse(0);
    check("pre_rst_tone", int'(dut.tone_env), 63);
    check("pre_rst_noise", int'(dut.noise_env), 31);
    n = 0;
    while (sample_out == 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("pre_rst_sample_nonzero",
          int'(sample_out != 0), 1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_rst_sample", int'(sample_out), 0);
    check("async_rst_audio", int'(audio_out), 0);
    check("async_rst_tone", int'(dut.tone_env), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    idle(5);
    pulse(0);
    check("post_rst_tone", int'(dut.tone_env), 63);
    check("post_rst_noise", int'(dut.noise_env), 0);
    check("post_rst_phase", int'(dut.phase), 0);

    prev = 0;
    for (int i = 0; i < 40; i++) begin
      idle(int'($urandom_range(1, 150)));
      if ($urandom_range(0, 1) == 1)
        fc = prev + int'($urandom_range(0, 2));
      else
        fc = int'($urandom_range(0, 2047));
      fc = fc % 2048;
      pulse(fc);
      check("rnd_tone", int'(dut.tone_env), m_tone);
      check("rnd_noise", int'(dut.noise_env), m_noise);
      check("rnd_step", int'(dut.cur_step), m_step);
      check("rnd_phase", int'(dut.phase), m_phase);
      prev = fc;
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/demo_audio.md
Name: demo_audio

Overview:
- Audio stage fed by graphics_top's frame timing (new_frame, frame_counter); drives demo_top's 1-bit audio_out.
- A 16-step pattern sequencer selects a square-wave tone and a noise-hat voice. Each voice has a per-frame decay envelope.
- The two voices are summed and converted to a 1-bit stream by a first-order sigma-delta modulator running every clk.

Parameters:
- FRAME_COUNTER_BITS, 11: width of frame_counter input.
- SAMPLE_DIV, 100: clk cycles per sample tick.
- PHASE_BITS, 14: tone phase accumulator width.
- FRAMES_PER_STEP_LOG2, 3: step index = frame_counter[FRAMES_PER_STEP_LOG2+3 : FRAMES_PER_STEP_LOG2].
- TONE_DECAY, 4: tone envelope decrement per frame.
- NOISE_DECAY, 8: noise envelope decrement per frame.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset; state is cleared while reset==0.
- new_frame  in  1  single-cycle pulse at frame start; frame_counter already holds the new frame number in that cycle.
- frame_counter  in  FRAME_COUNTER_BITS  current frame number.
- sample_out  out  7  current mixed sample, registered; for observation.
- audio_out  out  1  sigma-delta bitstream, registered.

Behaviour:
- Reset: all registers cleared as follows.
  - div_cnt, phase, tone_env, noise_env, acc, sample_out, audio_out, step_valid: 0.
  - cur_step: 0.
  - lfsr: 16'h0001.
- Sample tick:
  - div_cnt counts 0..SAMPLE_DIV-1 and wraps to 0.
  - tick is high in the cycle div_cnt==SAMPLE_DIV-1.
  - The divider is free-running and independent of new_frame.
- Note ROM: 16 entries of 8-bit phase increments, steps 0..15 = 32,0,40,0,48,0,40,32,36,0,48,0,54,48,40,0. An increment of 0 is a rest.
- On new_frame, compute s = step index from frame_counter.
  - If step_valid==0 or s!=cur_step:
    - cur_step<=s, step_valid<=1.
    - If inc[s]!=0: phase<=0, tone_env<=63. Else: tone_env<=0.
    - If s[1:0]==2'b10: noise_env<=31.
  - Otherwise (same step):
    - tone_env<=max(tone_env-TONE_DECAY, 0).
    - noise_env<=max(noise_env-NOISE_DECAY, 0).
    - Decrements saturate at 0 and never wrap.
- On tick:
  - phase<=phase+inc[cur_step], wrapping mod 2^PHASE_BITS.
  - lfsr<={fb, lfsr[15:1]}, where fb=lfsr[0]^lfsr[2]^lfsr[3]^lfsr[5].
  - If new_frame and tick coincide: the new_frame update of phase (reset to 0) wins. The LFSR still advances.
- Mix, registered every clk:
  - tone_s = phase[PHASE_BITS-1] ? tone_env : 0 (6b).
  - noise_s = lfsr[0] ? noise_env : 0 (5b).
  - sample_out <= tone_s + noise_s; maximum value 94, fits in 7 bits.
- Sigma-delta, every clk:
  - {c, acc} <= acc + sample_out, with 7-bit acc plus carry c.
  - audio_out <= c.
  - Constant sample_out=N gives exactly N ones per 128 clk cycles.
- Envelope timing:
  - Envelopes change only on new_frame cycles.
  - With no new_frame pulses, all state except div_cnt, phase, lfsr and acc holds.
- Reset mid-operation: outputs go to 0 immediately (asynchronous).
  - After release, the first new_frame always retriggers, because step_valid==0.

Test Plan:
- Reset, no new_frame for 1000 cycles -> audio_out==0, sample_out==0 throughout.
- Reset, then new_frame with frame_counter=0 -> step 0, tone_env=63, phase=0.
  - sample_out=0 for the first 256 ticks (25600 clk).
  - sample_out=63 for the next 256 ticks.
  - audio_out has 63 ones in every 128-cycle window during that time.
- Repeat new_frame with frame_counter=1..7 (same step 0) -> tone_env=59,55,51,47,43,39,35.
  - Then continue same-step frames for 16 frames total -> tone_env saturates at 0.
- frame_counter=8 (step 1, rest) -> tone_env=0, phase holds.
  - frame_counter=16 (step 2) -> tone retriggers at 63 with inc 40, and noise_env=31.
  - Same-step frames then take noise_env to 23,15,7,0,0.
- frame_counter 127 -> 128 -> step 15->0 change; tone retriggers at 63 with inc 32.
  - Assert new_frame in the same cycle as tick -> phase==0 next cycle.
- Mid-tone, pull reset low for 3 cycles -> all outputs 0 asynchronously.
  - Next new_frame with frame_counter=0 retriggers step 0 (tone_env=63) despite cur_step==0.
